// File: rtl/lvds_scan_ctrl.sv
// lvds_scan_ctrl
// Steps the LVDS clock-checker channel select across N_CH inputs. Each channel
// gets a settle interval, then a dwell during which the checker status bit is
// qualified over the final CHECK_CYCLES. After the last channel the per-channel
// pass vector is published and a saturating failed-scan counter is updated.
//
// State table
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for start, ch_sel parked
//   S_SWITCH | ch_sel just changed, mux/checker settling
//   S_DWELL  | checker evaluating; status qualified in the final window
//   S_SAMPLE | store pass flag for the current channel, advance or finish
//   S_DONE   | one-cycle done pulse, status_out/fail_cnt just published
//
// Ports
//   clk_fpga    in   system clock (100 MHz)
//   rst         in   synchronous active-high reset
//   start       in   begin a scan (honoured only in S_IDLE)
//   continuous  in   restart immediately after S_DONE when high
//   abort       in   drop the current scan, return to S_IDLE
//   chk_status  in   checker status, bit i valid while ch_sel == i
//   ch_sel      out  channel select to the LVDS mux and checker
//   busy        out  high in every state except S_IDLE
//   done        out  one-cycle pulse on scan completion
//   status_out  out  pass vector of the last completed scan
//   fail_cnt    out  saturating count of scans with any failed channel

module lvds_scan_ctrl #(
  parameter int N_CH          = 2,
  parameter int SETTLE_CYCLES = 8,
  parameter int DWELL_CYCLES  = 400,
  parameter int CHECK_CYCLES  = 200
) (
  input  logic                      clk_fpga,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      continuous,
  input  logic                      abort,
  input  logic [N_CH-1:0]           chk_status,
  output logic [$clog2(N_CH)-1:0]   ch_sel,
  output logic                      busy,
  output logic                      done,
  output logic [N_CH-1:0]           status_out,
  output logic [15:0]               fail_cnt
);

  localparam int SEL_W   = $clog2(N_CH);
  localparam int CNT_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CHECK_START = CNT_W'(DWELL_CYCLES - CHECK_CYCLES);
  localparam logic [SEL_W-1:0] LAST_CH     = SEL_W'(N_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SWITCH = 3'd1,
    S_DWELL  = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  ch_sel_q, ch_sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pass_q, pass_d;
  logic [N_CH-1:0]   scratch_q, scratch_d;
  logic [N_CH-1:0]   status_q, status_d;
  logic [15:0]       fail_cnt_q, fail_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d    = state_q;
    ch_sel_d   = ch_sel_q;
    cnt_d      = cnt_q;
    pass_d     = pass_q;
    scratch_d  = scratch_q;
    status_d   = status_q;
    fail_cnt_d = fail_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d  = S_SWITCH;
          ch_sel_d = '0;
          cnt_d    = SETTLE_LAST;
          pass_d   = 1'b1;
        end
      end

      // Settle timer is a down-counter; terminal count zero ends the interval.
      S_SWITCH: begin
        if (cnt_q == '0) begin
          state_d = S_DWELL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      // Dwell count runs upward so the check window is a simple threshold.
      S_DWELL: begin
        if ((cnt_q >= CHECK_START) && !chk_status[ch_sel_q]) begin
          pass_d = 1'b0;
        end
        if (cnt_q == DWELL_LAST) begin
          state_d = S_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Publishing on the last SAMPLE edge makes status_out/fail_cnt valid
      // in the same cycle that done is high.
      S_SAMPLE: begin
        scratch_d[ch_sel_q] = pass_q;
        if (ch_sel_q == LAST_CH) begin
          state_d  = S_DONE;
          status_d = scratch_d;
          if ((scratch_d != '1) && (fail_cnt_q != 16'hFFFF)) begin
            fail_cnt_d = fail_cnt_q + 16'd1;
          end
        end else begin
          state_d  = S_SWITCH;
          ch_sel_d = ch_sel_q + 1'b1;
          cnt_d    = SETTLE_LAST;
          pass_d   = 1'b1;
        end
      end

      S_DONE: begin
        if (continuous) begin
          state_d  = S_SWITCH;
          ch_sel_d = '0;
          cnt_d    = SETTLE_LAST;
          pass_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a pending publish in SAMPLE.
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      ch_sel_d   = '0;
      cnt_d      = '0;
      pass_d     = pass_q;
      scratch_d  = scratch_q;
      status_d   = status_q;
      fail_cnt_d = fail_cnt_q;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_fpga) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ch_sel_q   <= '0;
      cnt_q      <= '0;
      pass_q     <= 1'b0;
      scratch_q  <= '0;
      status_q   <= '0;
      fail_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_sel_q   <= ch_sel_d;
      cnt_q      <= cnt_d;
      pass_q     <= pass_d;
      scratch_q  <= scratch_d;
      status_q   <= status_d;
      fail_cnt_q <= fail_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ch_sel     = ch_sel_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign status_out = status_q;
  assign fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_lvds_scan_ctrl.sv
// Testbench for lvds_scan_ctrl: directed scenarios followed by randomized
// stimulus, all checked every cycle against a timeline model that derives the
// expected outputs from elapsed cycles since scan start.

module tb_lvds_scan_ctrl;

  localparam int N_CH   = 2;
  localparam int SETTLE = 8;
  localparam int DWELL  = 400;
  localparam int CHECK  = 200;
  localparam int PER_CH = SETTLE + DWELL + 1;
  localparam int SCAN   = N_CH * PER_CH;

  logic              clk_fpga = 1'b0;
  logic              rst;
  logic              start;
  logic              continuous;
  logic              abort;
  logic [N_CH-1:0]   chk_status;
  logic [0:0]        ch_sel;
  logic              busy;
  logic              done;
  logic [N_CH-1:0]   status_out;
  logic [15:0]       fail_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit              m_active;
  int              m_t;
  int              m_sel;
  logic [N_CH-1:0] m_pass;
  logic [N_CH-1:0] m_status;
  int              m_fail;

  lvds_scan_ctrl #(
    .N_CH(N_CH), .SETTLE_CYCLES(SETTLE), .DWELL_CYCLES(DWELL), .CHECK_CYCLES(CHECK)
  ) dut (
    .clk_fpga(clk_fpga), .rst(rst), .start(start), .continuous(continuous),
    .abort(abort), .chk_status(chk_status), .ch_sel(ch_sel), .busy(busy),
    .done(done), .status_out(status_out), .fail_cnt(fail_cnt)
  );

  always #5 clk_fpga = ~clk_fpga;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp_v);
    end
  endtask

  // Advances the model across one clock edge using the inputs present there.
  task automatic model_step();
    int ch, off;
    if (rst) begin
      m_active = 0; m_t = 0; m_sel = 0; m_pass = '0; m_status = '0; m_fail = 0;
    end else if (!m_active) begin
      if (start && !abort) begin
        m_active = 1; m_t = 0; m_sel = 0; m_pass = '1;
      end
    end else if (abort) begin
      m_active = 0; m_sel = 0;
    end else if (m_t == SCAN) begin
      if (continuous) begin
        m_t = 0; m_sel = 0; m_pass = '1;
      end else begin
        m_active = 0;
      end
    end else begin
      ch  = m_t / PER_CH;
      off = m_t % PER_CH;
      if (off >= SETTLE + DWELL - CHECK && off < SETTLE + DWELL && !chk_status[ch])
        m_pass[ch] = 1'b0;
      if (m_t == SCAN - 1) begin
        m_status = m_pass;
        if (m_pass != '1 && m_fail < 16'hFFFF) m_fail++;
      end
      m_t++;
      m_sel = (m_t / PER_CH > N_CH - 1) ? N_CH - 1 : m_t / PER_CH;
    end
  endtask

  task automatic cyc();
    @(posedge clk_fpga);
    model_step();
    #1;
    chk("busy",       32'(busy),       32'(m_active));
    chk("done",       32'(done),       32'(m_active && m_t == SCAN));
    chk("ch_sel",     32'(ch_sel),     32'(m_sel));
    chk("status_out", 32'(status_out), 32'(m_status));
    chk("fail_cnt",   32'(fail_cnt),   32'(m_fail));
    @(negedge clk_fpga);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0; chk_status = '1;
    run(2);
    rst = 1'b0;
    run(3);

    // Nominal scan
    chk_status = 2'b11;
    pulse_start();
    run(SCAN + 5);

    // Low pulse inside channel 1 check window (dwell count 250)
    pulse_start();
    run(PER_CH + SETTLE + 250);
    chk_status = 2'b01; cyc(); chk_status = 2'b11;
    run(200);

    // Low pulse outside the window (dwell count 150)
    pulse_start();
    run(PER_CH + SETTLE + 150);
    chk_status = 2'b01; cyc(); chk_status = 2'b11;
    run(300);

    // Continuous mode, then drop continuous mid-scan
    continuous = 1'b1; chk_status = 2'b10;
    pulse_start();
    run(3 * (SCAN + 1) + 100);
    continuous = 1'b0;
    run(SCAN + 20);

    // Abort during channel 1 dwell, with a stray start while busy
    chk_status = 2'b11;
    pulse_start();
    run(PER_CH + 100);
    pulse_start();
    run(50);
    abort = 1'b1; cyc(); abort = 1'b0;
    run(20);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
    run(5);

    // Reset mid-dwell after a failing scan, then a nominal scan
    chk_status = 2'b01;
    pulse_start();
    run(SCAN + 5);
    pulse_start();
    run(300);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk_status = 2'b11;
    pulse_start();
    run(SCAN + 5);

    // Randomized stimulus
    for (int i = 0; i < 40000; i++) begin
      start  = ($urandom_range(0, 199) == 0);
      abort  = ($urandom_range(0, 3999) == 0);
      rst    = ($urandom_range(0, 19999) == 0);
      if ($urandom_range(0, 1499) == 0) continuous = ~continuous;
      for (int b = 0; b < N_CH; b++)
        chk_status[b] = ($urandom_range(0, 299) != 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
